// File: rtl/fifo_ctrl.sv
// Pointer/strobe controller for an external DEPTH-entry FIFO. Strobes are combinational from push/pop.
// Status flags, count and rd_valid are registered. A push while full is refused unless a pop is accepted.
module fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic             err_clr,
    output logic             wren,
    output logic             WrInc,
    output logic             WrPtrClr,
    output logic             rden,
    output logic             RdInc,
    output logic             RdPtrClr,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             rd_valid,
    output logic             overflow,
    output logic             underflow
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;

    logic run;
    logic flush_run;
    logic pop_acc;
    logic push_acc;
    logic wr_wrap;
    logic rd_wrap;
    logic push_rej;
    logic pop_rej;

    assign run       = (state == RUN);
    assign flush_run = run & flush;
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign wr_wrap   = (wr_idx == LAST_IDX);
    assign rd_wrap   = (rd_idx == LAST_IDX);

    // A pop frees a slot in the same cycle, so a full FIFO may still take a push alongside it.
    assign pop_acc  = run & pop & ~empty & ~flush;
    assign push_acc = run & push & ~flush & (~full | pop_acc);
    assign push_rej = run & push & ~flush & ~push_acc;
    assign pop_rej  = run & pop & ~flush & ~pop_acc;

    // The last slot clears the pointer instead of incrementing it, so it never leaves 0..DEPTH-1.
    always_comb begin
        wren     = push_acc;
        WrInc    = push_acc & ~wr_wrap;
        WrPtrClr = ~run | flush_run | (push_acc & wr_wrap);
        rden     = pop_acc;
        RdInc    = pop_acc & ~rd_wrap;
        RdPtrClr = ~run | flush_run | (pop_acc & rd_wrap);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= INIT;
            count     <= '0;
            wr_idx    <= '0;
            rd_idx    <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= push_rej | (overflow & ~err_clr);
            underflow <= pop_rej | (underflow & ~err_clr);
            rd_valid  <= pop_acc;
            case (state)
                INIT: begin
                    state  <= RUN;
                    count  <= '0;
                    wr_idx <= '0;
                    rd_idx <= '0;
                end
                RUN: begin
                    if (flush) begin
                        count  <= '0;
                        wr_idx <= '0;
                        rd_idx <= '0;
                    end else begin
                        if (push_acc) begin
                            wr_idx <= wr_wrap ? '0 : wr_idx + IDX_W'(1);
                        end
                        if (pop_acc) begin
                            rd_idx <= rd_wrap ? '0 : rd_idx + IDX_W'(1);
                        end
                        case ({push_acc, pop_acc})
                            2'b10:   count <= count + CNT_W'(1);
                            2'b01:   count <= count - CNT_W'(1);
                            default: count <= count;
                        endcase
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: an attached FIFO memory follows the strobes, a queue model predicts
// acceptance, flags and read data; a monitor checks data on every rd_valid.
module tb_fifo_ctrl;
    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic wren, WrInc, WrPtrClr, rden, RdInc, RdPtrClr;
    logic full, empty, rd_valid, overflow, underflow;
    logic [CNT_W-1:0] count;

    fifo_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .err_clr(err_clr),
        .wren(wren), .WrInc(WrInc), .WrPtrClr(WrPtrClr),
        .rden(rden), .RdInc(RdInc), .RdPtrClr(RdPtrClr),
        .full(full), .empty(empty), .count(count),
        .rd_valid(rd_valid), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Attached FIFO storage driven purely by the controller's strobes.
    logic [15:0] mem [DEPTH];
    logic [15:0] data_in = '0;
    logic [15:0] data_out = '0;
    int wp = 0, rp = 0;

    always @(posedge clk) begin
        if (wren && wp < DEPTH) mem[wp] <= data_in;
        if (WrPtrClr) wp <= 0; else if (WrInc) wp <= wp + 1;
        if (rden && rp < DEPTH) data_out <= mem[rp];
        if (RdPtrClr) rp <= 0; else if (RdInc) rp <= rp + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model
    int q[$];
    int exp_q[$];
    bit m_run = 0, m_ov = 0, m_uf = 0, m_rdv = 0;
    int wr_pos = 0, rd_pos = 0;
    int next_data = 'h101;
    int max_cnt = 0;

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 1, 0);
            else chk("rd_data", data_out, exp_q.pop_front());
        end
        if (wp >= DEPTH || rp >= DEPTH) chk("ptr_range", 1, 0);
    end

    task automatic model_clear();
        q.delete();
        exp_q.delete();
        m_run = 0; m_ov = 0; m_uf = 0; m_rdv = 0;
        wr_pos = 0; rd_pos = 0;
    endtask

    // Called at a falling edge; checks registered state, drives one cycle, checks strobes.
    task automatic cyc(bit pu, bit po, bit fl, bit ec, bit wait_end = 1'b1);
        bit fm, em, pa, ua;
        chk("count", count, q.size());
        chk("full", full, q.size() == DEPTH);
        chk("empty", empty, q.size() == 0);
        chk("overflow", overflow, m_ov);
        chk("underflow", underflow, m_uf);
        chk("rd_valid", rd_valid, m_rdv);
        push = pu; pop = po; flush = fl; err_clr = ec;
        data_in = next_data[15:0];
        fm = (q.size() == DEPTH);
        em = (q.size() == 0);
        pa = m_run && po && !em && !fl;
        ua = m_run && pu && !fl && (!fm || pa);
        #1;
        chk("wren", wren, ua);
        chk("rden", rden, pa);
        chk("WrInc", WrInc, ua && wr_pos != DEPTH - 1);
        chk("RdInc", RdInc, pa && rd_pos != DEPTH - 1);
        chk("WrPtrClr", WrPtrClr, !m_run || fl || (ua && wr_pos == DEPTH - 1));
        chk("RdPtrClr", RdPtrClr, !m_run || fl || (pa && rd_pos == DEPTH - 1));
        if (!m_run) begin
            wr_pos = 0; rd_pos = 0;
        end else if (fl) begin
            q.delete();
            wr_pos = 0; rd_pos = 0;
        end else begin
            if (pa) begin
                exp_q.push_back(q.pop_front());
                rd_pos = (rd_pos + 1) % DEPTH;
            end
            if (ua) begin
                q.push_back(next_data);
                wr_pos = (wr_pos + 1) % DEPTH;
                next_data++;
            end
        end
        if (m_run && !fl && pu && !ua) m_ov = 1; else if (ec) m_ov = 0;
        if (m_run && !fl && po && !pa) m_uf = 1; else if (ec) m_uf = 0;
        m_rdv = pa;
        m_run = 1;
        if (q.size() > max_cnt) max_cnt = q.size();
        if (wait_end) @(negedge clk);
    endtask

    task automatic do_reset(int n);
        rst = 1; push = 0; pop = 0; flush = 0; err_clr = 0;
        model_clear();
        repeat (n) begin
            @(negedge clk);
            chk("rst_count", count, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_rd_valid", rd_valid, 0);
            chk("rst_overflow", overflow, 0);
            chk("rst_underflow", underflow, 0);
            chk("rst_wr_strobes", {wren, WrInc, WrPtrClr}, 3'b001);
            chk("rst_rd_strobes", {rden, RdInc, RdPtrClr}, 3'b001);
        end
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset(3);
        cyc(1, 0, 0, 0);                   // INIT cycle: push must be ignored
        repeat (2) cyc(0, 0, 0, 0);

        // Fill and drain
        repeat (DEPTH) cyc(1, 0, 0, 0);
        repeat (DEPTH) cyc(0, 1, 0, 0);
        repeat (2) cyc(0, 0, 0, 0);

        // Wrap with bursts of five
        max_cnt = 0;
        repeat (4) begin
            repeat (5) cyc(1, 0, 0, 0);
            repeat (5) cyc(0, 1, 0, 0);
        end
        cyc(0, 0, 0, 0);
        chk("wrap_max_count", max_cnt, 5);

        // Full: push+pop together, then push alone, then clear
        repeat (DEPTH) cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 1);
        repeat (DEPTH) cyc(0, 1, 0, 0);

        // Empty: pop alone, push+pop together
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);

        // Flush at count 6 with a push in the same cycle
        repeat (6) cyc(1, 0, 0, 0);
        cyc(1, 0, 1, 0);
        repeat (2) cyc(0, 0, 0, 0);

        // Reset pulse in the middle of a drain
        repeat (4) cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0, 1'b0);
        @(posedge clk);
        #1 rst = 1;
        #1;
        chk("mid_rst_rd_valid", rd_valid, 0);
        chk("mid_rst_count", count, 0);
        do_reset(2);
        repeat (3) cyc(0, 0, 0, 0);

        // Randomized traffic
        repeat (600) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset(1);
            end else begin
                cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                    $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10);
            end
        end

        repeat (3) cyc(0, 0, 0, 0);
        chk("exp_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
